alu_result_collector: RTL and testbench

//  Initiator-side response collector for the ALU_design command interface.

---
 rtl/alu_result_collector_if.sv | 53 +++++
 rtl/alu_result_collector.sv | 177 +++++++++++++++++
 tb/tb_alu_result_collector.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_collector_if.sv
// ---------------------------------------------------------------------------
// alu_result_collector_if
// Bundles the signals between the ALU initiator, the ALU result/flag outputs,
// the collector and the downstream result consumer.
//
// Signals
//   issue, issue_cmd, issue_mode  command presented to the ALU this cycle
//   res, cout, oflow, g, e, l, err ALU result and flags
//   busy                           collector cannot accept an issue this cycle
//   out_valid/out_ready            valid/ready handshake of the result FIFO head
//   out_cmd, out_mode              command and mode of the head entry
//   out_res, out_flags             captured result and {cout,oflow,g,e,l,err}
//   drop                           one-cycle pulse on rejected issue or lost result
//
// Modports
//   slave  : the collector itself
//   master : the environment (initiator, ALU and consumer)
// ---------------------------------------------------------------------------
interface alu_result_collector_if #(
  parameter int WIDTH_O = 8,
  parameter int WIDTH_C = 4
);
  localparam int RW = 2 * WIDTH_O + 1;

  logic               issue;
  logic [WIDTH_C-1:0] issue_cmd;
  logic               issue_mode;
  logic [RW-1:0]      res;
  logic               cout;
  logic               oflow;
  logic               g;
  logic               e;
  logic               l;
  logic               err;
  logic               busy;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH_C-1:0] out_cmd;
  logic               out_mode;
  logic [RW-1:0]      out_res;
  logic [5:0]         out_flags;
  logic               drop;

  modport slave (
    input  issue, issue_cmd, issue_mode, res, cout, oflow, g, e, l, err, out_ready,
    output busy, out_valid, out_cmd, out_mode, out_res, out_flags, drop
  );

  modport master (
    output issue, issue_cmd, issue_mode, res, cout, oflow, g, e, l, err, out_ready,
    input  busy, out_valid, out_cmd, out_mode, out_res, out_flags, drop
  );
endinterface

// File: rtl/alu_result_collector.sv
// ---------------------------------------------------------------------------
// alu_result_collector
// Initiator-side response collector for the ALU command interface. Every
// accepted command is tracked through a delay line; on the edge its result
// matures (LAT cycles for ordinary commands, MLAT for MODE=1 CMD 9/10
// multiplies) the ALU result and flags are written into an in-order
// first-word-fall-through FIFO, which is drained over a valid/ready port.
//
// Ports
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    alu_result_collector_if.slave (issue side, ALU outputs, result port)
//   res_cnt  out [7:0]  FIFO captures, saturating    (ALU_COLLECT_CNT_EN only)
//   drop_cnt out [7:0]  dropped events, saturating   (ALU_COLLECT_CNT_EN only)
//
// Configuration
//   ALU_COLLECT_CNT_EN  when defined, adds the res_cnt/drop_cnt counters.
// ---------------------------------------------------------------------------
module alu_result_collector #(
  parameter int WIDTH_O = 8,
  parameter int WIDTH_C = 4,
  parameter int LAT     = 1,
  parameter int MLAT    = 2,
  parameter int DEPTH   = 4
) (
  input  logic clk,
  input  logic rst_n,
  alu_result_collector_if.slave bus
`ifdef ALU_COLLECT_CNT_EN
  ,
  output logic [7:0] res_cnt,
  output logic [7:0] drop_cnt
`endif
);

  localparam int RW = 2 * WIDTH_O + 1;
  localparam int AW = $clog2(DEPTH);
  // Stages 1..BW holding a multiply would collide with a new ordinary entry.
  localparam int BW = MLAT - LAT;

  // Delay line, stage index = number of edges since the issue was accepted.
  logic [MLAT:1]      st_valid;
  logic [MLAT:1]      st_mult;
  logic [MLAT:1]      st_mode;
  logic [WIDTH_C-1:0] st_cmd [1:MLAT];

  logic busy;
  logic accept;
  logic reject;
  logic is_mult;

  always_comb begin
    busy = 1'b0;
    for (int k = 1; k <= BW; k++) begin
      if (st_valid[k] && st_mult[k]) busy = 1'b1;
    end
  end

  assign is_mult = bus.issue_mode &&
                   ((bus.issue_cmd == WIDTH_C'(9)) || (bus.issue_cmd == WIDTH_C'(10)));
  assign accept  = bus.issue && !busy;
  assign reject  = bus.issue && busy;

  // Ordinary entries are invalidated once they pass stage LAT so that only
  // multiplies travel on to stage MLAT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid <= '0;
      st_mult  <= '0;
      st_mode  <= '0;
      for (int k = 1; k <= MLAT; k++) st_cmd[k] <= '0;
    end else begin
      st_valid[1] <= accept;
      st_mult[1]  <= is_mult;
      st_mode[1]  <= bus.issue_mode;
      st_cmd[1]   <= bus.issue_cmd;
      for (int k = 2; k <= MLAT; k++) begin
        st_valid[k] <= st_valid[k-1] && (st_mult[k-1] || ((k - 1) < LAT));
        st_mult[k]  <= st_mult[k-1];
        st_mode[k]  <= st_mode[k-1];
        st_cmd[k]   <= st_cmd[k-1];
      end
    end
  end

  // At most one entry can mature per edge because the busy window prevents
  // an ordinary and a multiply from lining up.
  logic               cap_ord;
  logic               cap_mul;
  logic               capture;
  logic [WIDTH_C-1:0] cap_cmd;
  logic               cap_mode;

  assign cap_ord  = st_valid[LAT] && !st_mult[LAT];
  assign cap_mul  = st_valid[MLAT] && st_mult[MLAT];
  assign capture  = cap_ord || cap_mul;
  assign cap_cmd  = cap_ord ? st_cmd[LAT] : st_cmd[MLAT];
  assign cap_mode = cap_ord ? st_mode[LAT] : st_mode[MLAT];

  // Result FIFO; the extra pointer bit separates full from empty.
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [WIDTH_C-1:0] mem_cmd   [DEPTH];
  logic [DEPTH-1:0]   mem_mode;
  logic [RW-1:0]      mem_res   [DEPTH];
  logic [5:0]         mem_flags [DEPTH];

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic lost;
  logic drop_q;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && bus.out_ready;
  assign push  = capture && (!full || pop);
  assign lost  = capture && full && !pop;

  // Storage is cleared on reset so the head outputs read as zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_mode <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_cmd[i]   <= '0;
        mem_res[i]   <= '0;
        mem_flags[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_cmd[wr_ptr[AW-1:0]]   <= cap_cmd;
        mem_mode[wr_ptr[AW-1:0]]  <= cap_mode;
        mem_res[wr_ptr[AW-1:0]]   <= bus.res;
        mem_flags[wr_ptr[AW-1:0]] <= {bus.cout, bus.oflow, bus.g, bus.e, bus.l, bus.err};
        wr_ptr                    <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // A rejected issue and a lost result on the same edge give a single pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= 1'b0;
    else        drop_q <= reject || lost;
  end

  assign bus.busy      = busy;
  assign bus.drop      = drop_q;
  assign bus.out_valid = !empty;
  assign bus.out_cmd   = mem_cmd[rd_ptr[AW-1:0]];
  assign bus.out_mode  = mem_mode[rd_ptr[AW-1:0]];
  assign bus.out_res   = mem_res[rd_ptr[AW-1:0]];
  assign bus.out_flags = mem_flags[rd_ptr[AW-1:0]];

`ifdef ALU_COLLECT_CNT_EN
  // drop_cnt counts both events separately even when they share one pulse.
  logic [1:0] drop_inc;
  logic [8:0] drop_sum;

  assign drop_inc = {1'b0, reject} + {1'b0, lost};
  assign drop_sum = {1'b0, drop_cnt} + {7'b0, drop_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (push && (res_cnt != 8'hFF)) res_cnt <= res_cnt + 8'd1;
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_collector.sv
// ---------------------------------------------------------------------------
// tb_alu_result_collector
// Self-checking bench for alu_result_collector (LAT=1, MLAT=2, DEPTH=4).
// A per-cycle vector table covers the single-result, multiply collision,
// overflow and full-with-pop cases; hand-written sequences cover in-order
// delivery under random back-pressure and asynchronous reset with a full
// FIFO. Define ALU_COLLECT_CNT_EN to also check the counters.
// ---------------------------------------------------------------------------
module tb_alu_result_collector;

  localparam int WO    = 8;
  localparam int WC    = 4;
  localparam int LAT   = 1;
  localparam int MLAT  = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  alu_result_collector_if #(.WIDTH_O(WO), .WIDTH_C(WC)) bus ();

`ifdef ALU_COLLECT_CNT_EN
  logic [7:0] res_cnt;
  logic [7:0] drop_cnt;
`endif

  alu_result_collector #(
    .WIDTH_O(WO), .WIDTH_C(WC), .LAT(LAT), .MLAT(MLAT), .DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ALU_COLLECT_CNT_EN
    ,
    .res_cnt  (res_cnt),
    .drop_cnt (drop_cnt)
`endif
  );

  typedef struct {
    logic        iss;
    logic [3:0]  cmd;
    logic        mode;
    logic [16:0] res;
    logic [5:0]  flg;
    logic        rdy;
    logic        e_busy;
    logic        e_drop;
    logic        e_valid;
    logic [3:0]  e_cmd;
    logic        e_mode;
    logic [16:0] e_res;
    logic [5:0]  e_flg;
  } vec_t;

  typedef struct {
    logic [3:0]  cmd;
    logic [16:0] res;
    logic [5:0]  flg;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic iss, input logic [3:0] cmd, input logic mode,
                              input logic [16:0] res, input logic [5:0] flg, input logic rdy,
                              input logic eb, input logic ed, input logic ev,
                              input logic [3:0] ec, input logic em,
                              input logic [16:0] er, input logic [5:0] ef);
    vec_t v;
    v.iss = iss; v.cmd = cmd; v.mode = mode; v.res = res; v.flg = flg; v.rdy = rdy;
    v.e_busy = eb; v.e_drop = ed; v.e_valid = ev;
    v.e_cmd = ec; v.e_mode = em; v.e_res = er; v.e_flg = ef;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    bus.issue      = v.iss;
    bus.issue_cmd  = v.cmd;
    bus.issue_mode = v.mode;
    bus.res        = v.res;
    {bus.cout, bus.oflow, bus.g, bus.e, bus.l, bus.err} = v.flg;
    bus.out_ready  = v.rdy;
  endtask

  task automatic drive_idle();
    apply_stimulus(mk(0, 0, 0, 17'h0, 6'h0, 0, 0, 0, 0, 0, 0, 17'h0, 6'h0));
  endtask

  // Head fields are only compared when the row expects a valid head.
  task automatic check_row(input int i, input vec_t v);
    logic [30:0] act;
    logic [30:0] exp;
    act = {bus.busy, bus.drop, bus.out_valid, 28'h0};
    exp = {v.e_busy, v.e_drop, v.e_valid, 28'h0};
    if (v.e_valid) begin
      act[27:0] = {bus.out_cmd, bus.out_mode, bus.out_res, bus.out_flags};
      exp[27:0] = {v.e_cmd, v.e_mode, v.e_res, v.e_flg};
    end
    check_output($sformatf("row%0d", i), 64'(act), 64'(exp));
  endtask

  initial begin
    int issued;
    int cyc;

    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_output("reset_state",
                 64'({bus.busy, bus.drop, bus.out_valid, bus.out_cmd, bus.out_mode, bus.out_res, bus.out_flags}),
                 64'h0);

    // Single result with COUT set
    vq.push_back(mk(1, 4'h0, 1, 17'h000, 6'h00, 0,  0, 0, 0, 4'h0, 0, 17'h000, 6'h00));
    vq.push_back(mk(0, 4'h0, 0, 17'h1FE, 6'h20, 0,  0, 0, 0, 4'h0, 0, 17'h000, 6'h00));
    vq.push_back(mk(0, 4'h0, 0, 17'h000, 6'h00, 1,  0, 0, 1, 4'h0, 1, 17'h1FE, 6'h20));
    vq.push_back(mk(0, 4'h0, 0, 17'h000, 6'h00, 0,  0, 0, 0, 4'h0, 0, 17'h000, 6'h00));
    // Multiply followed by an ordinary issue in the collision window
    vq.push_back(mk(1, 4'h9, 1, 17'h000, 6'h00, 0,  0, 0, 0, 4'h0, 0, 17'h000, 6'h00));
    vq.push_back(mk(1, 4'h1, 1, 17'h0AA, 6'h00, 0,  1, 0, 0, 4'h0, 0, 17'h000, 6'h00));
    vq.push_back(mk(0, 4'h0, 0, 17'h030, 6'h04, 0,  0, 1, 0, 4'h0, 0, 17'h000, 6'h00));
    vq.push_back(mk(0, 4'h0, 0, 17'h000, 6'h00, 1,  0, 0, 1, 4'h9, 1, 17'h030, 6'h04));
    vq.push_back(mk(0, 4'h0, 0, 17'h000, 6'h00, 0,  0, 0, 0, 4'h0, 0, 17'h000, 6'h00));
    // Five back-to-back issues with no consumer: fifth result is lost
    vq.push_back(mk(1, 4'h2, 0, 17'h000, 6'h00, 0,  0, 0, 0, 4'h0, 0, 17'h000, 6'h00));
    vq.push_back(mk(1, 4'h3, 0, 17'h101, 6'h01, 0,  0, 0, 0, 4'h0, 0, 17'h000, 6'h00));
    vq.push_back(mk(1, 4'h4, 0, 17'h102, 6'h02, 0,  0, 0, 1, 4'h2, 0, 17'h101, 6'h01));
    vq.push_back(mk(1, 4'h5, 0, 17'h103, 6'h03, 0,  0, 0, 1, 4'h2, 0, 17'h101, 6'h01));
    vq.push_back(mk(1, 4'h6, 0, 17'h104, 6'h04, 0,  0, 0, 1, 4'h2, 0, 17'h101, 6'h01));
    vq.push_back(mk(0, 4'h0, 0, 17'h105, 6'h05, 0,  0, 0, 1, 4'h2, 0, 17'h101, 6'h01));
    vq.push_back(mk(0, 4'h0, 0, 17'h000, 6'h00, 0,  0, 1, 1, 4'h2, 0, 17'h101, 6'h01));
    vq.push_back(mk(0, 4'h0, 0, 17'h000, 6'h00, 1,  0, 0, 1, 4'h2, 0, 17'h101, 6'h01));
    vq.push_back(mk(0, 4'h0, 0, 17'h000, 6'h00, 1,  0, 0, 1, 4'h3, 0, 17'h102, 6'h02));
    vq.push_back(mk(0, 4'h0, 0, 17'h000, 6'h00, 1,  0, 0, 1, 4'h4, 0, 17'h103, 6'h03));
    vq.push_back(mk(0, 4'h0, 0, 17'h000, 6'h00, 1,  0, 0, 1, 4'h5, 0, 17'h104, 6'h04));
    // Full FIFO with a pop on the edge the fifth result matures
    vq.push_back(mk(1, 4'h1, 0, 17'h000, 6'h00, 0,  0, 0, 0, 4'h0, 0, 17'h000, 6'h00));
    vq.push_back(mk(1, 4'h7, 0, 17'h111, 6'h11, 0,  0, 0, 0, 4'h0, 0, 17'h000, 6'h00));
    vq.push_back(mk(1, 4'h8, 0, 17'h112, 6'h12, 0,  0, 0, 1, 4'h1, 0, 17'h111, 6'h11));
    vq.push_back(mk(1, 4'hB, 0, 17'h113, 6'h13, 0,  0, 0, 1, 4'h1, 0, 17'h111, 6'h11));
    vq.push_back(mk(1, 4'hC, 0, 17'h114, 6'h14, 0,  0, 0, 1, 4'h1, 0, 17'h111, 6'h11));
    vq.push_back(mk(0, 4'h0, 0, 17'h115, 6'h15, 1,  0, 0, 1, 4'h1, 0, 17'h111, 6'h11));
    vq.push_back(mk(0, 4'h0, 0, 17'h000, 6'h00, 1,  0, 0, 1, 4'h7, 0, 17'h112, 6'h12));
    vq.push_back(mk(0, 4'h0, 0, 17'h000, 6'h00, 1,  0, 0, 1, 4'h8, 0, 17'h113, 6'h13));
    vq.push_back(mk(0, 4'h0, 0, 17'h000, 6'h00, 1,  0, 0, 1, 4'hB, 0, 17'h114, 6'h14));
    vq.push_back(mk(0, 4'h0, 0, 17'h000, 6'h00, 1,  0, 0, 1, 4'hC, 0, 17'h115, 6'h15));
    vq.push_back(mk(0, 4'h0, 0, 17'h000, 6'h00, 0,  0, 0, 0, 4'h0, 0, 17'h000, 6'h00));

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      check_row(i, vq[i]);
      apply_stimulus(vq[i]);
    end
    @(negedge clk);
    drive_idle();
    check_output("after_table_empty", 64'(bus.out_valid), 64'(0));
`ifdef ALU_COLLECT_CNT_EN
    check_output("res_cnt", 64'(res_cnt), 64'(11));
    check_output("drop_cnt", 64'(drop_cnt), 64'(2));
`endif

    // Ten issues under random back-pressure; results must come out in order.
    issued = 0;
    for (cyc = 0; cyc < 200 && (issued < 10 || sb.size() > 0); cyc++) begin
      @(negedge clk);
      check_output("rand_drop", 64'(bus.drop), 64'(0));
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check_output("rand_unexpected_pop", 64'(1), 64'(0));
        end else begin
          check_output($sformatf("rand_head%0d", cyc),
                       64'({bus.out_cmd, bus.out_mode, bus.out_res, bus.out_flags}),
                       64'({sb[0].cmd, 1'b0, sb[0].res, sb[0].flg}));
          void'(sb.pop_front());
        end
      end
      bus.res = 17'h200 + 17'(cyc);
      {bus.cout, bus.oflow, bus.g, bus.e, bus.l, bus.err} = 6'(cyc);
      if (issued < 10 && sb.size() < DEPTH) begin
        bus.issue      = 1'b1;
        bus.issue_cmd  = 4'(issued);
        bus.issue_mode = 1'b0;
        sb.push_back('{4'(issued), 17'h200 + 17'(cyc + 1), 6'(cyc + 1)});
        issued++;
      end else begin
        bus.issue = 1'b0;
      end
    end
    check_output("rand_complete", 64'({issued == 10, sb.size() == 0}), 64'(2'b11));
    @(negedge clk);
    drive_idle();

    // Fill the FIFO, put a multiply in flight, then reset mid-stream.
    for (int i = 0; i < 4; i++) begin
      bus.issue      = 1'b1;
      bus.issue_cmd  = 4'(i + 1);
      bus.issue_mode = 1'b0;
      bus.res        = 17'h0AB + 17'(i);
      @(negedge clk);
    end
    bus.issue_cmd  = 4'h9;
    bus.issue_mode = 1'b1;
    bus.res        = 17'h0AF;
    @(negedge clk);
    drive_idle();
    check_output("pre_reset_busy_valid", 64'({bus.busy, bus.out_valid}), 64'(2'b11));
    #1 rst_n = 1'b0;
    #1;
    check_output("reset_outputs",
                 64'({bus.busy, bus.drop, bus.out_valid, bus.out_cmd, bus.out_mode, bus.out_res, bus.out_flags}),
                 64'h0);
`ifdef ALU_COLLECT_CNT_EN
    check_output("reset_counters", 64'({res_cnt, drop_cnt}), 64'h0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("post_release",
                 64'({bus.busy, bus.drop, bus.out_valid}), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
